// File: rtl/boot_loader_ctrl_if.sv
// ---------------------------------------------------------------------------
// boot_loader_ctrl_if
// Bundles the word-stream handshake and the imem/dmem write bus of the boot
// loader.
//   s_valid/s_data/s_ready : incoming program/data word stream
//   imem_we/dmem_we        : one-cycle write strobes to the two memories
//   mem_addr/mem_wdata     : byte address and data of the current write
// Modports:
//   master : the loader itself (consumes the stream, drives the write bus)
//   slave  : the environment (host stream source plus memory write ports)
// ---------------------------------------------------------------------------
interface boot_loader_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// boot_loader_ctrl
// Sequenced boot/program loader. Streams words into instruction or data
// memory at auto-incrementing byte addresses, range-checks each load, keeps
// a running checksum and holds the CPU in reset until released with go.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a load (ignored while loading)
//   target            : 0 = imem, 1 = dmem (latched on start)
//   base_addr         : byte start address (latched on start)
//   word_count        : words to load (latched on start)
//   go                : release the CPU from DONE
//   bus               : stream handshake + memory write bus (master side)
//   cpu_reset         : reset to the CPU core, low only in RUN
//   busy / done / err : state flags for LOAD / DONE / ERR
//   checksum          : sum of words accepted in the current load
// ---------------------------------------------------------------------------
module boot_loader_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 512,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    target,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        word_count,
    input  logic                    go,
    boot_loader_ctrl_if.master      bus,
    output logic                    cpu_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_W-1:0]       checksum
);

    localparam int STEP  = DATA_W / 8;
    localparam int SUM_W = CNT_W + ADDR_W;

    typedef enum logic [2:0] {IDLE, LOAD, DONE, RUN, ERR} state_t;

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] ptrReg, ptrNext;
    logic [CNT_W-1:0]  remainReg, remainNext;
    logic              targetReg, targetNext;
    logic [DATA_W-1:0] checksumReg, checksumNext;
    logic [ADDR_W-1:0] memAddrReg, memAddrNext;
    logic [DATA_W-1:0] memWdataReg, memWdataNext;
    logic              imemWeReg, imemWeNext;
    logic              dmemWeReg, dmemWeNext;
    logic              sReadyReg, busyReg, doneReg, errReg, cpuResetReg;

    // Range check of the requested load. The end index is formed at
    // CNT_W+ADDR_W bits so a huge base plus count cannot wrap into range.
    logic [ADDR_W-1:0] baseWord;
    logic              aligned;
    logic [SUM_W-1:0]  endWord;
    logic [SUM_W-1:0]  depthSel;
    logic              rangeOk;
    logic              canStart;

    assign baseWord = base_addr / ADDR_W'(STEP);
    assign aligned  = (base_addr % ADDR_W'(STEP)) == '0;
    assign endWord  = SUM_W'(baseWord) + SUM_W'(word_count);
    assign depthSel = target ? SUM_W'(DMEM_DEPTH) : SUM_W'(IMEM_DEPTH);
    assign rangeOk  = aligned && (endWord <= depthSel);
    assign canStart = start && (stateReg != LOAD);

    always_comb begin
        stateNext    = stateReg;
        ptrNext      = ptrReg;
        remainNext   = remainReg;
        targetNext   = targetReg;
        checksumNext = checksumReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        imemWeNext   = 1'b0;
        dmemWeNext   = 1'b0;

        case (stateReg)
            LOAD: begin
                // s_ready is always high in LOAD, so s_valid alone accepts.
                if (bus.s_valid) begin
                    imemWeNext   = !targetReg;
                    dmemWeNext   = targetReg;
                    memAddrNext  = ptrReg;
                    memWdataNext = bus.s_data;
                    checksumNext = checksumReg + bus.s_data;
                    ptrNext      = ptrReg + ADDR_W'(STEP);
                    remainNext   = remainReg - CNT_W'(1);
                    if (remainReg == CNT_W'(1)) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (go) begin
                    stateNext = RUN;
                end
            end
            default: ;
        endcase

        // A new start overrides everything outside LOAD, including go in DONE.
        if (canStart) begin
            checksumNext = '0;
            targetNext   = target;
            ptrNext      = base_addr;
            remainNext   = word_count;
            if (!rangeOk) begin
                stateNext = ERR;
            end else if (word_count == '0) begin
                stateNext = DONE;
            end else begin
                stateNext = LOAD;
            end
        end
    end

    // State flags are registered from the next state so every output
    // comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            ptrReg      <= '0;
            remainReg   <= '0;
            targetReg   <= 1'b0;
            checksumReg <= '0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            imemWeReg   <= 1'b0;
            dmemWeReg   <= 1'b0;
            sReadyReg   <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            errReg      <= 1'b0;
            cpuResetReg <= 1'b1;
        end else begin
            stateReg    <= stateNext;
            ptrReg      <= ptrNext;
            remainReg   <= remainNext;
            targetReg   <= targetNext;
            checksumReg <= checksumNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
            imemWeReg   <= imemWeNext;
            dmemWeReg   <= dmemWeNext;
            sReadyReg   <= (stateNext == LOAD);
            busyReg     <= (stateNext == LOAD);
            doneReg     <= (stateNext == DONE);
            errReg      <= (stateNext == ERR);
            cpuResetReg <= (stateNext != RUN);
        end
    end

    assign bus.s_ready   = sReadyReg;
    assign bus.imem_we   = imemWeReg;
    assign bus.dmem_we   = dmemWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign cpu_reset     = cpuResetReg;
    assign busy          = busyReg;
    assign done          = doneReg;
    assign err           = errReg;
    assign checksum      = checksumReg;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_loader_ctrl
// Directed bench for boot_loader_ctrl. Stimulus pushes each expected memory
// write into a queue; an independent monitor pops and compares on every
// write strobe. Status outputs are checked directly at chosen points.
// ---------------------------------------------------------------------------
module tb_boot_loader_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              target = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              go = 1'b0;
    logic              cpu_reset, busy, done, err;
    logic [DATA_W-1:0] checksum;

    boot_loader_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    boot_loader_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .IMEM_DEPTH(512), .DMEM_DEPTH(512), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .base_addr(base_addr), .word_count(word_count), .go(go),
        .bus(bus),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        tgt;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1 || bus.dmem_we === 1'b1) begin
            if (bus.imem_we === 1'b1 && bus.dmem_we === 1'b1) begin
                check("both_we", 32'd1, 32'd0);
            end
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("wr_target", {31'd0, bus.dmem_we}, {31'd0, e.tgt});
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input logic tgt, input logic [31:0] base, input logic [15:0] cnt);
        start      = 1'b1;
        target     = tgt;
        base_addr  = base;
        word_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic expectWrite(input logic tgt, input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.tgt  = tgt;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic sendWord(input logic [31:0] d);
        check("s_ready_load", {31'd0, bus.s_ready}, 32'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // 1. reset
        tick();
        tick();
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        reset = 1'b0;
        tick();

        // 2. imem, base 0, three back-to-back words
        startLoad(1'b0, 32'h0, 16'd3);
        check("t2_busy", {31'd0, busy}, 32'd1);
        expectWrite(1'b0, 32'h0, 32'h11);
        expectWrite(1'b0, 32'h4, 32'h22);
        expectWrite(1'b0, 32'h8, 32'h33);
        sendWord(32'h11);
        sendWord(32'h22);
        sendWord(32'h33);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_s_ready_off", {31'd0, bus.s_ready}, 32'd0);
        check("t2_checksum", checksum, 32'h66);
        tick();

        // 3. dmem, base 0x10, gapped stream, then go
        startLoad(1'b1, 32'h10, 16'd2);
        check("t3_checksum_clr", checksum, 32'd0);
        expectWrite(1'b1, 32'h10, 32'hA5);
        expectWrite(1'b1, 32'h14, 32'h5A);
        sendWord(32'hA5);
        tick();
        tick();
        check("t3_checksum_hold", checksum, 32'hA5);
        check("t3_addr_hold", bus.mem_addr, 32'h10);
        sendWord(32'h5A);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_checksum", checksum, 32'hFF);
        check("t3_cpu_reset_done", {31'd0, cpu_reset}, 32'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("t3_cpu_released", {31'd0, cpu_reset}, 32'd0);
        check("t3_done_off", {31'd0, done}, 32'd0);

        // 4. out of range in dmem (510+3 > 512), then zero-count load
        startLoad(1'b1, 32'h7F8, 16'd3);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t4_s_ready", {31'd0, bus.s_ready}, 32'd0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h99;
        tick();
        tick();
        tick();
        bus.s_valid = 1'b0;
        check("t4_err_hold", {31'd0, err}, 32'd1);
        startLoad(1'b0, 32'h0, 16'd0);
        check("t4_zero_done", {31'd0, done}, 32'd1);
        check("t4_zero_err", {31'd0, err}, 32'd0);
        check("t4_zero_busy", {31'd0, busy}, 32'd0);

        // 5. misaligned base, then reset in the middle of a load
        startLoad(1'b0, 32'h2, 16'd1);
        check("t5_misaligned_err", {31'd0, err}, 32'd1);
        startLoad(1'b0, 32'h100, 16'd4);
        check("t5_busy", {31'd0, busy}, 32'd1);
        expectWrite(1'b0, 32'h100, 32'hDEADBEEF);
        sendWord(32'hDEADBEEF);
        check("t5_checksum_partial", checksum, 32'hDEADBEEF);
        reset       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0BAD;
        tick();
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_checksum", checksum, 32'd0);
        check("t5_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t5_rst_addr", bus.mem_addr, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        bus.s_valid = 1'b0;
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_done", {31'd0, done}, 32'd0);
        check("t5_idle_s_ready", {31'd0, bus.s_ready}, 32'd0);

        // 6. start from RUN, then start and go together in DONE
        startLoad(1'b0, 32'h0, 16'd0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("t6_run", {31'd0, cpu_reset}, 32'd0);
        startLoad(1'b0, 32'h20, 16'd1);
        check("t6_cpu_reset_back", {31'd0, cpu_reset}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd1);
        expectWrite(1'b0, 32'h20, 32'h77);
        sendWord(32'h77);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_checksum", checksum, 32'h77);
        go = 1'b1;
        startLoad(1'b1, 32'h0, 16'd2);
        go = 1'b0;
        check("t6_start_wins_busy", {31'd0, busy}, 32'd1);
        check("t6_start_wins_cpu", {31'd0, cpu_reset}, 32'd1);
        expectWrite(1'b1, 32'h0, 32'h1);
        expectWrite(1'b1, 32'h4, 32'h2);
        sendWord(32'h1);
        sendWord(32'h2);
        check("t6_done2", {31'd0, done}, 32'd1);
        check("t6_checksum2", checksum, 32'h3);

        tick();
        tick();
        check("queue_empty", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Parametrised successor to the CPU top's reset-time external write mux: a sequenced boot/program loader.
- Streams words over a valid/ready handshake into instruction or data memory at auto-incrementing addresses.
- Range-checks each transfer, keeps a running checksum, and holds the CPU core in reset until software releases it with `go`.
- Sits between the external host interface and the imem/dmem write ports of the CPU top.

Parameters:
DATA_W, 32, memory word width in bits; must be a multiple of 8.
ADDR_W, 32, byte-address width.
IMEM_DEPTH, 512, instruction memory depth in words.
DMEM_DEPTH, 512, data memory depth in words.
CNT_W, 16, width of word_count.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a load; sampled in IDLE, DONE, RUN and ERR.
target  in  1  0 selects imem, 1 selects dmem; latched on an accepted start.
base_addr  in  ADDR_W  byte start address; latched on an accepted start.
word_count  in  CNT_W  number of words to load; latched on an accepted start.
go  in  1  releases the CPU; acted on in DONE only.
s_valid  in  1  stream word valid.
s_data  in  DATA_W  stream word.
s_ready  out  1  loader can accept a stream word.
imem_we  out  1  instruction memory write strobe.
dmem_we  out  1  data memory write strobe.
mem_addr  out  ADDR_W  byte address of the current write.
mem_wdata  out  DATA_W  write data.
cpu_reset  out  1  reset to the CPU core.
busy  out  1  high while in LOAD.
done  out  1  high while in DONE.
err  out  1  high while in ERR.
checksum  out  DATA_W  sum of words accepted in the current load, modulo 2^DATA_W.

Behaviour:
- Word step: STEP = DATA_W/8 bytes.
- States: IDLE, LOAD, DONE, RUN, ERR. All outputs are registered.
- Reset (from any state, including mid-LOAD):
  - next state IDLE;
  - cpu_reset=1;
  - s_ready=0, imem_we=0, dmem_we=0, busy=0, done=0, err=0;
  - mem_addr=0, mem_wdata=0, checksum=0;
  - any partial load is discarded; no write strobe is issued in the cycle after reset.
- cpu_reset is 1 in every state except RUN, where it is 0.
- Start acceptance (in IDLE, DONE, RUN or ERR):
  - checksum clears to 0.
  - Range check: base_addr must be a multiple of STEP, and base_addr/STEP + word_count must not exceed the selected depth. The sum is computed with no overflow (width CNT_W+ADDR_W).
  - Range-check failure -> ERR.
  - word_count==0 -> DONE.
  - Otherwise -> LOAD, with the address pointer = base_addr and remaining = word_count.
  - Start while in RUN re-asserts cpu_reset in the next cycle.
- LOAD:
  - s_ready=1 in every LOAD cycle; the loader never back-pressures inside LOAD.
  - A word is accepted when s_valid && s_ready.
  - On acceptance, in the next cycle: the selected we pulses high for exactly one cycle, mem_addr = pointer, mem_wdata = s_data, checksum += s_data.
  - On acceptance the pointer advances by STEP and remaining decrements.
  - Write latency is 1 cycle from acceptance.
  - Back-to-back acceptance gives one write per cycle.
  - s_valid low: no write; all other outputs hold.
  - start during LOAD is ignored.
  - When the last word is accepted (remaining==1), the next state is DONE. s_ready is 0 in that next cycle, while the last write pulse occurs in that same cycle.
- Writes in the two-memory split: never both imem_we and dmem_we in the same cycle. Write strobes are 0 outside the cycle following an acceptance.
- DONE:
  - done=1 and checksum is stable.
  - go=1 -> RUN.
  - start has priority over go when both are high.
- RUN: cpu_reset=0; stays in RUN until start or reset.
- ERR: err=1; no writes; leaves only on an accepted start (re-evaluated) or reset.
- mem_addr and mem_wdata hold their last written values outside write cycles.

Test Plan:
1. reset held 2 cycles -> cpu_reset=1, all strobes 0, checksum=0, state IDLE (busy/done/err=0).
2. start, target=0, base=0x0, count=3; stream 0x11,0x22,0x33 back-to-back -> imem_we pulses at cycles +1,+2,+3 with addr 0x0,0x4,0x8; done=1; checksum=0x66; dmem_we never high.
3. target=1, base=0x10, count=2 with s_valid gapped (1,0,0,1) -> dmem_we only the cycle after each accept at addr 0x10,0x14; go -> cpu_reset falls next cycle.
4. base=0x7F8, count=3, DMEM_DEPTH=512 (510+3>512) -> err=1, no writes, s_ready=0; then a start with count=0 -> done=1 with no writes.
5. base=0x2 (misaligned) -> ERR; reset asserted mid-LOAD after 1 of 4 words -> no further strobes, checksum=0, IDLE.
6. In RUN, start with count=1 -> cpu_reset=1 next cycle, one write performed, DONE; go and start asserted together in DONE -> start wins, state LOAD.
